// File: rtl/packet_resolver_pkg.sv
// Shared types for the packet resolver: stat FIFO entry layout, size limits
// and the drain sequencer state encoding.
package packet_resolver_pkg;

  localparam int MIN_PCKT_SIZE = 8;
  localparam int MAX_PCKT_SIZE = 190;
  localparam int LEN_WIDTH     = 8;
  localparam int AST_DWIDTH    = 64;
  localparam int CHANNEL_WIDTH = 1;
  localparam int EMPTY_WIDTH   = $clog2(AST_DWIDTH / 8);

  typedef struct packed {
    logic                     drop;
    logic [CHANNEL_WIDTH-1:0] channel;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [LEN_WIDTH-1:0]     len_words;
  } stat_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } drain_state_t;

endpackage

// File: rtl/packet_drain_ctrl_if.sv
// Avalon-ST link between the drain sequencer (src) and its consumer (sink).
interface packet_drain_ctrl_if #(
  parameter int DWIDTH        = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int EMPTY_WIDTH   = 3
);
  logic [DWIDTH-1:0]        data;
  logic                     valid;
  logic                     ready;
  logic                     startofpacket;
  logic                     endofpacket;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic [CHANNEL_WIDTH-1:0] channel;

  modport src  (output data, valid, startofpacket, endofpacket, empty, channel, input ready);
  modport sink (input data, valid, startofpacket, endofpacket, empty, channel, output ready);
endinterface

// File: rtl/packet_drain_ctrl_word_counter.sv
// Word position counter for one packet: wraps to zero on the last counted word
// and flags the first and last word positions against the latched length.
module pkt_word_counter #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 inc_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic [LEN_WIDTH-1:0] cnt_o,
  output logic                 first_o,
  output logic                 last_o
);
  logic [LEN_WIDTH-1:0] cnt_r;
  logic                 last_s;

  assign last_s  = (cnt_r == (len_i - LEN_WIDTH'(1)));
  assign cnt_o   = cnt_r;
  assign first_o = (cnt_r == {LEN_WIDTH{1'b0}});
  assign last_o  = last_s;

  // Position register: advances per counted word, back to zero after the last one.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      cnt_r <= {LEN_WIDTH{1'b0}};
    end else if (inc_i) begin
      cnt_r <= last_s ? {LEN_WIDTH{1'b0}} : (cnt_r + LEN_WIDTH'(1));
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule

// File: rtl/packet_drain_ctrl.sv
// Read-side sequencer for the resolver FIFOs: pops one descriptor per packet,
// then forwards or flushes that packet's words, with framing check and counters.
module packet_drain_ctrl #(
  parameter int AST_DWIDTH    = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int LEN_WIDTH     = 8,
  parameter int CNT_WIDTH     = 32,
  parameter int EMPTY_WIDTH   = $clog2(AST_DWIDTH / 8),
  parameter int STAT_W        = 1 + CHANNEL_WIDTH + EMPTY_WIDTH + LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  en_i,
  input  logic                  stat_empty_i,
  input  logic [STAT_W-1:0]     stat_q_i,
  output logic                  stat_rdreq_o,
  input  logic                  data_empty_i,
  input  logic [AST_DWIDTH+1:0] data_q_i,
  output logic                  data_rdreq_o,
  packet_drain_ctrl_if.src      ast_src_if,
  output logic [CNT_WIDTH-1:0]  fwd_cnt_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o,
  output logic                  err_o
);
  import packet_resolver_pkg::*;

  drain_state_t             state_r, next_state_s;
  logic [LEN_WIDTH-1:0]     len_r;
  logic [EMPTY_WIDTH-1:0]   empty_r;
  logic [CHANNEL_WIDTH-1:0] channel_r;
  logic                     drop_r;
  logic [CNT_WIDTH-1:0]     fwd_cnt_r, drop_cnt_r;
  logic                     err_r;

  logic [LEN_WIDTH-1:0]     desc_len_s, word_cnt_s;
  logic [EMPTY_WIDTH-1:0]   desc_empty_s;
  logic [CHANNEL_WIDTH-1:0] desc_channel_s;
  logic                     desc_drop_s, len_zero_s, head_sop_s, head_eop_s;
  logic                     first_s, last_s, stat_rdreq_s, data_pop_s;
  logic                     valid_s, sop_s, eop_s, frame_err_s;
  logic [AST_DWIDTH-1:0]    data_s;
  logic [EMPTY_WIDTH-1:0]   ast_empty_s;
  logic [CHANNEL_WIDTH-1:0] ast_channel_s;

  assign desc_len_s     = stat_q_i[LEN_WIDTH-1:0];
  assign desc_empty_s   = stat_q_i[LEN_WIDTH +: EMPTY_WIDTH];
  assign desc_channel_s = stat_q_i[LEN_WIDTH+EMPTY_WIDTH +: CHANNEL_WIDTH];
  assign desc_drop_s    = stat_q_i[STAT_W-1];
  assign len_zero_s     = (desc_len_s == {LEN_WIDTH{1'b0}});
  assign head_sop_s     = data_q_i[AST_DWIDTH+1];
  assign head_eop_s     = data_q_i[AST_DWIDTH];
  assign frame_err_s    = data_pop_s && ((head_sop_s != first_s) || (head_eop_s != last_s));

  pkt_word_counter #(.LEN_WIDTH(LEN_WIDTH)) u_word_cnt (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .inc_i   (data_pop_s),
    .len_i   (len_r),
    .cnt_o   (word_cnt_s),
    .first_o (first_s),
    .last_o  (last_s)
  );

  // State register.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: a zero-length descriptor is consumed but starts no packet.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (stat_rdreq_s && !len_zero_s) begin
          next_state_s = desc_drop_s ? ST_DROP : ST_FWD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FWD, ST_DROP: begin
        if (data_pop_s && last_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode: framing is derived from the descriptor, never from the FIFO flags.
  always_comb begin
    stat_rdreq_s  = 1'b0;
    data_pop_s    = 1'b0;
    valid_s       = 1'b0;
    sop_s         = 1'b0;
    eop_s         = 1'b0;
    data_s        = {AST_DWIDTH{1'b0}};
    ast_empty_s   = {EMPTY_WIDTH{1'b0}};
    ast_channel_s = {CHANNEL_WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: stat_rdreq_s = en_i && !stat_empty_i;
      ST_FWD: begin
        valid_s       = !data_empty_i;
        sop_s         = first_s;
        eop_s         = last_s;
        data_s        = data_q_i[AST_DWIDTH-1:0];
        ast_empty_s   = last_s ? empty_r : {EMPTY_WIDTH{1'b0}};
        ast_channel_s = channel_r;
        data_pop_s    = !data_empty_i && ast_src_if.ready;
      end
      ST_DROP: data_pop_s = !data_empty_i;
      default: data_pop_s = 1'b0;
    endcase
  end

  // Descriptor latch, packet counters and sticky consistency error.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      len_r      <= {LEN_WIDTH{1'b0}};
      empty_r    <= {EMPTY_WIDTH{1'b0}};
      channel_r  <= {CHANNEL_WIDTH{1'b0}};
      drop_r     <= 1'b0;
      fwd_cnt_r  <= {CNT_WIDTH{1'b0}};
      drop_cnt_r <= {CNT_WIDTH{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if (stat_rdreq_s) begin
        len_r     <= desc_len_s;
        empty_r   <= desc_empty_s;
        channel_r <= desc_channel_s;
        drop_r    <= desc_drop_s;
      end
      if (data_pop_s && last_s && (state_r == ST_FWD)) begin
        fwd_cnt_r <= fwd_cnt_r + CNT_WIDTH'(1);
      end
      if (data_pop_s && last_s && (state_r == ST_DROP)) begin
        drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
      end
      if ((stat_rdreq_s && len_zero_s) || frame_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign stat_rdreq_o             = stat_rdreq_s;
  assign data_rdreq_o             = data_pop_s;
  assign ast_src_if.valid         = valid_s;
  assign ast_src_if.data          = data_s;
  assign ast_src_if.startofpacket = sop_s;
  assign ast_src_if.endofpacket   = eop_s;
  assign ast_src_if.empty         = ast_empty_s;
  assign ast_src_if.channel       = ast_channel_s;
  assign fwd_cnt_o                = fwd_cnt_r;
  assign drop_cnt_o               = drop_cnt_r;
  assign err_o                    = err_r;

  logic unused_s;
  assign unused_s = drop_r ^ (^word_cnt_s);
endmodule

// File: tb/tb_packet_drain_ctrl.sv
// Directed plus randomized bench: show-ahead FIFO models feed the sequencer and
// a packet-level reference model predicts every beat, counter and error flag.
module tb_packet_drain_ctrl;
  import packet_resolver_pkg::*;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        stat_empty, stat_rdreq, data_empty, data_rdreq, err;
  logic [12:0] stat_q;
  logic [65:0] data_q;
  logic [31:0] fwd_cnt, drop_cnt;

  always #5 clk = ~clk;

  packet_drain_ctrl_if #(.DWIDTH(64), .CHANNEL_WIDTH(1), .EMPTY_WIDTH(3)) ast ();

  packet_drain_ctrl dut (
    .clk_i        (clk),
    .srst_i       (rst),
    .en_i         (en),
    .stat_empty_i (stat_empty),
    .stat_q_i     (stat_q),
    .stat_rdreq_o (stat_rdreq),
    .data_empty_i (data_empty),
    .data_q_i     (data_q),
    .data_rdreq_o (data_rdreq),
    .ast_src_if   (ast),
    .fwd_cnt_o    (fwd_cnt),
    .drop_cnt_o   (drop_cnt),
    .err_o        (err)
  );

  // Show-ahead FIFO models
  stat_entry_t stat_mem [DEPTH];
  logic [65:0] data_mem [DEPTH];
  int          stat_wr = 0, stat_rd = 0, data_wr = 0, data_rd = 0;
  logic        flush = 1'b0;

  assign stat_empty = (stat_rd == stat_wr);
  assign data_empty = (data_rd == data_wr);
  assign stat_q     = stat_mem[stat_rd[11:0]];
  assign data_q     = data_mem[data_rd[11:0]];

  always @(posedge clk) begin
    if (flush) begin
      stat_rd <= stat_wr;
      data_rd <= data_wr;
    end else begin
      if (stat_rdreq) stat_rd <= stat_rd + 1;
      if (data_rdreq) data_rd <= data_rd + 1;
    end
  end

  // Sink-side monitor: records each handshake one half-cycle ahead of its edge
  logic [69:0] cap_q [$];
  logic        cap_err [$];
  int          stab_viol = 0, bad_pop = 0;
  logic        hold_pend = 1'b0;
  logic [69:0] hold_beat, beat;

  always @(negedge clk) begin
    beat = {ast.channel, ast.empty, ast.startofpacket, ast.endofpacket, ast.data};
    if (hold_pend && (!ast.valid || beat != hold_beat)) stab_viol++;
    if (rst) begin
      hold_pend = 1'b0;
    end else if (ast.valid && ast.ready) begin
      cap_q.push_back(beat);
      cap_err.push_back(err);
      hold_pend = 1'b0;
    end else if (ast.valid) begin
      hold_pend = 1'b1;
      hold_beat = beat;
    end else begin
      hold_pend = 1'b0;
    end
    if ((stat_rdreq && stat_empty) || (data_rdreq && data_empty)) bad_pop++;
  end

  // Reference model state
  logic [69:0] exp_q [$];
  int          fwd_exp = 0, drop_exp = 0, chk_idx = 0;
  logic        err_exp = 1'b0;
  int          n_cmp = 0, n_err = 0;
  int          ready_mode = 0;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ast.ready = 1'b1;
        1:       ast.ready = ~ast.ready;
        default: ast.ready = ($urandom_range(3, 0) != 0);
      endcase
    end
  endtask

  // Queues one descriptor and its words; words from index 'split' arrive after a gap.
  task automatic push_pkt(input int len, input bit drop, input int emp, input bit ch,
                          input int bad_eop_at, input int split);
    stat_entry_t d;
    logic [63:0] w;
    logic        sop, eop;
    d.drop      = drop;
    d.channel   = ch;
    d.empty     = emp[2:0];
    d.len_words = len[7:0];
    stat_mem[stat_wr] = d;
    stat_wr++;
    for (int i = 0; i < len; i++) begin
      if (i == split) tick(6);
      w   = {$urandom, $urandom};
      sop = (i == 0);
      eop = (i == len - 1) || (i == bad_eop_at);
      data_mem[data_wr] = {sop, eop, w};
      data_wr++;
      if (eop != (i == len - 1)) err_exp = 1'b1;
      if (!drop) exp_q.push_back({ch, (i == len - 1) ? emp[2:0] : 3'd0, sop, (i == len - 1), w});
    end
    if (len == 0) err_exp = 1'b1;
    else if (drop) drop_exp++;
    else fwd_exp++;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c = 0;
    while ((stat_rd != stat_wr || data_rd != data_wr) && c < budget) begin
      tick(1);
      c++;
    end
    check({tag, "_drain_in_time"}, 70'(c < budget), 70'(1));
    tick(3);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_beats"}, 70'(cap_q.size()), 70'(exp_q.size()));
    for (int i = chk_idx; i < cap_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), cap_q[i], exp_q[i]);
    chk_idx = cap_q.size();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_fwd_cnt"},  70'(fwd_cnt),  70'(fwd_exp));
    check({tag, "_drop_cnt"}, 70'(drop_cnt), 70'(drop_exp));
    check({tag, "_err"},      70'(err),      70'(err_exp));
    check({tag, "_protocol"}, 70'(bad_pop + stab_viol), 70'(0));
  endtask

  initial begin
    int c, base;
    ast.ready = 1'b1;

    // Reset state
    tick(2);
    check("rst_valid", 70'(ast.valid), 70'(0));
    check("rst_rdreq", 70'({stat_rdreq, data_rdreq}), 70'(0));
    check_state("rst");
    rst = 1'b0;
    tick(2);
    en = 1'b1;

    // 1: forward len=8 empty=3, no bubbles (stat pop + 8 beats = 9 cycles)
    push_pkt(8, 1'b0, 3, 1'b1, -1, 99);
    c = 0;
    while (data_rd != data_wr && c < 50) begin tick(1); c++; end
    check("t1_cycles", 70'(c), 70'(9));
    tick(3);
    check_stream("t1");
    check_state("t1");

    // 2: drop a max-size packet, then forward len=8
    push_pkt(MAX_PCKT_SIZE, 1'b1, 0, 1'b0, -1, 999);
    push_pkt(8, 1'b0, 5, 1'b0, -1, 99);
    wait_drain("t2", 600);
    check_stream("t2");
    check_state("t2");

    // 3: toggling ready, plus a data FIFO underrun mid-packet
    ready_mode = 1;
    push_pkt(10, 1'b0, 7, 1'b1, -1, 4);
    wait_drain("t3", 200);
    ready_mode = 0;
    tick(1);
    check_stream("t3");
    check_state("t3");

    // 4: enable dropped mid-packet finishes the packet, holds the next descriptor
    base = cap_q.size();
    push_pkt(20, 1'b0, 1, 1'b0, -1, 99);
    push_pkt(5, 1'b0, 2, 1'b1, -1, 99);
    c = 0;
    while (cap_q.size() < base + 3 && c < 100) begin tick(1); c++; end
    en = 1'b0;
    tick(40);
    check("t4_beats_gated", 70'(cap_q.size()), 70'(base + 20));
    check("t4_stat_pending", 70'(stat_wr - stat_rd), 70'(1));
    en = 1'b1;
    wait_drain("t4", 100);
    check_stream("t4");
    check_state("t4");

    // Randomized mix under random backpressure
    ready_mode = 2;
    for (int p = 0; p < 12; p++)
      push_pkt($urandom_range(48, MIN_PCKT_SIZE), 1'($urandom_range(1, 0)),
               $urandom_range(7, 0), 1'($urandom_range(1, 0)), -1, 999);
    wait_drain("rnd", 3000);
    ready_mode = 0;
    tick(1);
    check_stream("rnd");
    check_state("rnd");

    // 5: stray eop on word 5 raises err at that pop, framing still from descriptor
    base = cap_q.size();
    push_pkt(8, 1'b0, 4, 1'b0, 5, 99);
    wait_drain("t5", 100);
    check_stream("t5");
    check("t5_err_before_w5", 70'(cap_err[base + 5]), 70'(0));
    check("t5_err_after_w5",  70'(cap_err[base + 6]), 70'(1));
    check_state("t5");

    // 6: async reset mid-packet at word 4
    base = cap_q.size();
    push_pkt(8, 1'b0, 0, 1'b1, -1, 99);
    c = 0;
    while (cap_q.size() < base + 4 && c < 50) begin tick(1); c++; end
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 70'(ast.valid), 70'(0));
    check("t6_rst_ast", 70'({ast.channel, ast.empty, ast.startofpacket, ast.endofpacket, ast.data}), 70'(0));
    check("t6_rst_rdreq", 70'({stat_rdreq, data_rdreq}), 70'(0));
    check("t6_rst_cnt", 70'({fwd_cnt, drop_cnt, err}), 70'(0));
    while (exp_q.size() > cap_q.size()) void'(exp_q.pop_back());
    fwd_exp = 0; drop_exp = 0; err_exp = 1'b0;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    rst = 1'b0;
    tick(2);
    push_pkt(8, 1'b0, 6, 1'b0, -1, 99);
    wait_drain("t6", 100);
    check_stream("t6");
    check_state("t6");

    // 5b: zero-length descriptor is consumed without popping data
    push_pkt(0, 1'b1, 0, 1'b0, -1, 99);
    push_pkt(8, 1'b0, 2, 1'b1, -1, 99);
    wait_drain("t5b", 100);
    check_stream("t5b");
    check_state("t5b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
